// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-ported memory between MIPS fetch and data stages.
// Optional round-robin tie-break when MIPS_MEM_ARB_RR_EN is defined (default: data wins ties).
module mips_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          cnt_r;
    logic                win_d_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   i_rdata_r;
    logic [DATA_W-1:0]   d_rdata_r;
    logic                any_req_s;
    logic                pick_d_s;

    assign any_req_s = i_req | d_req;

`ifdef MIPS_MEM_ARB_RR_EN
    logic last_gnt_r;

    // Remember which side won the most recent grant (1 = data).
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_r <= 1'b1;
        end else if (state_r == ST_IDLE && any_req_s) begin
            last_gnt_r <= pick_d_s;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

    // Round-robin tie-break: on a tie grant the side not served last.
    always_comb begin
        pick_d_s = d_req;
        if (i_req && d_req) begin
            pick_d_s = ~last_gnt_r;
        end else begin
            pick_d_s = d_req;
        end
    end
`else
    // Fixed priority: data wins whenever it requests.
    always_comb begin
        pick_d_s = d_req;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; BUSY exits once the wait-state counter has drained.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Grant latch, wait-state counter and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= 4'd0;
            win_d_r   <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            i_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        win_d_r <= pick_d_s;
                        we_r    <= pick_d_s & d_we;
                        addr_r  <= pick_d_s ? d_addr : i_addr;
                        wdata_r <= pick_d_s ? d_wdata : {DATA_W{1'b0}};
                        cnt_r   <= CNT_LOAD;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else if (!win_d_r) begin
                        i_rdata_r <= mem_rdata;
                    end else if (!we_r) begin
                        d_rdata_r <= mem_rdata;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Memory strobes and acks decode straight from registered state.
    assign mem_en    = (state_r == ST_BUSY);
    assign mem_we    = (state_r == ST_BUSY) & we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign i_ack     = (state_r == ST_RESP) & ~win_d_r;
    assign d_ack     = (state_r == ST_RESP) & win_d_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; extra instances cover WAIT_CYCLES = 0 and 3.
module tb_mips_mem_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        rst, i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        z_i_ack, z_d_ack, z_mem_en, z_mem_we, z_busy;
    logic [31:0] z_i_rdata, z_d_rdata, z_mem_addr, z_mem_wdata;
    logic        t_i_ack, t_d_ack, t_mem_en, t_mem_we, t_busy;
    logic [31:0] t_i_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;

    logic        mem_init, force_en;
    logic [31:0] force_val;
    logic [31:0] mem_dev [16];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(z_i_ack), .i_rdata(z_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(z_d_ack),
        .d_rdata(z_d_rdata), .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(mem_rdata), .busy(z_busy));

    mips_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_ack(t_i_ack), .i_rdata(t_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(t_d_ack),
        .d_rdata(t_d_rdata), .mem_en(t_mem_en), .mem_we(t_mem_we), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_rdata(mem_rdata), .busy(t_busy));

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    // Behavioural memory device attached to the WAIT_CYCLES=1 instance.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem_dev[i] <= init_val(i);
        end else if (mem_en && mem_we) begin
            mem_dev[mem_addr[5:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = force_en ? force_val : mem_dev[mem_addr[5:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_init = 1'b0; force_en = 1'b0; force_val = 32'h0;
        tick(); tick();
        chk_cnt++; if ({mem_en, mem_we, i_ack, d_ack, busy} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {mem_en, mem_we, i_ack, d_ack, busy}); else pass_cnt++;
        chk_cnt++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL reset_mem: got %h expected 0", {mem_addr, mem_wdata}); else pass_cnt++;
        chk_cnt++; if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", {i_rdata, d_rdata}); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        i_req = 1'b1; i_addr = 32'h400; force_en = 1'b1; force_val = 32'h2008_000A;
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk_cnt++; if ({mem_en, mem_we, busy, i_ack} !== 4'b1010) $display("FAIL fetch_busy c%0d: got %b expected 1010", c, {mem_en, mem_we, busy, i_ack}); else pass_cnt++;
            chk_cnt++; if (mem_addr !== 32'h400) $display("FAIL fetch_addr c%0d: got %h expected 400", c, mem_addr); else pass_cnt++;
        end
        tick();
        chk_cnt++; if ({i_ack, d_ack, mem_en} !== 3'b100) $display("FAIL fetch_ack: got %b expected 100", {i_ack, d_ack, mem_en}); else pass_cnt++;
        chk_cnt++; if (i_rdata !== 32'h2008_000A) $display("FAIL fetch_rdata: got %h expected 2008000a", i_rdata); else pass_cnt++;
        i_req = 1'b0;
        tick();
        chk_cnt++; if ({busy, i_ack} !== 2'b00) $display("FAIL fetch_idle: got %b expected 00", {busy, i_ack}); else pass_cnt++;
        settle();
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk_cnt++; if ({mem_en, mem_we} !== 2'b11) $display("FAIL store_we c%0d: got %b expected 11", c, {mem_en, mem_we}); else pass_cnt++;
            chk_cnt++; if ({mem_addr, mem_wdata} !== {32'h1000, 32'hDEAD_BEEF}) $display("FAIL store_bus c%0d: got %h expected 00001000deadbeef", c, {mem_addr, mem_wdata}); else pass_cnt++;
            d_addr = 32'h3000; d_wdata = 32'h0;
        end
        tick();
        chk_cnt++; if ({d_ack, i_ack, mem_en, mem_we} !== 4'b1000) $display("FAIL store_ack: got %b expected 1000", {d_ack, i_ack, mem_en, mem_we}); else pass_cnt++;
        chk_cnt++; if (d_rdata !== 32'h0) $display("FAIL store_rdata: got %h expected 0", d_rdata); else pass_cnt++;
        chk_cnt++; if (mem_dev[0] !== 32'hDEAD_BEEF) $display("FAIL store_mem: got %h expected deadbeef", mem_dev[0]); else pass_cnt++;
        settle();
    endtask

    task automatic test_tie();
        logic       first_d;
        logic [1:0] exp;
        logic [31:0] got;
`ifdef MIPS_MEM_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        i_req = 1'b1; i_addr = 32'h408; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        force_en = 1'b1; force_val = 32'h1111_2222;
        for (int c = 1; c <= 8; c++) begin
            tick();
            exp = 2'b00;
            if (c == 3) exp = first_d ? 2'b01 : 2'b10;
            if (c == 7) exp = first_d ? 2'b10 : 2'b01;
            chk_cnt++; if ({i_ack, d_ack} !== exp) $display("FAIL tie_ack c%0d: got %b expected %b", c, {i_ack, d_ack}, exp); else pass_cnt++;
            if (c == 3) begin
                got = first_d ? d_rdata : i_rdata;
                chk_cnt++; if (got !== 32'h1111_2222) $display("FAIL tie_first_rdata: got %h expected 11112222", got); else pass_cnt++;
                if (first_d) d_req = 1'b0; else i_req = 1'b0;
                force_val = 32'h3333_4444;
            end
            if (c == 7) begin
                got = first_d ? i_rdata : d_rdata;
                chk_cnt++; if (got !== 32'h3333_4444) $display("FAIL tie_second_rdata: got %h expected 33334444", got); else pass_cnt++;
                i_req = 1'b0; d_req = 1'b0;
            end
        end
        settle();
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp;
        i_req = 1'b1; i_addr = 32'h40C; force_en = 1'b1; force_val = 32'h55AA_55AA;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_cnt++; if ({mem_en, i_ack, busy} !== 3'b000) $display("FAIL rstmid_ctrl: got %b expected 000", {mem_en, i_ack, busy}); else pass_cnt++;
        chk_cnt++; if ({i_rdata, d_rdata} !== 64'h0) $display("FAIL rstmid_rdata: got %h expected 0", {i_rdata, d_rdata}); else pass_cnt++;
        rst = 1'b0; i_req = 1'b0;
        tick();
        i_req = 1'b1; i_addr = 32'h410; force_val = 32'h0BAD_F00D;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp = (c == 3) ? 2'b10 : 2'b00;
            chk_cnt++; if ({i_ack, d_ack} !== exp) $display("FAIL rstmid_fresh_ack c%0d: got %b expected %b", c, {i_ack, d_ack}, exp); else pass_cnt++;
            if (c == 3) begin
                chk_cnt++; if (i_rdata !== 32'h0BAD_F00D) $display("FAIL rstmid_fresh_rdata: got %h expected 0badf00d", i_rdata); else pass_cnt++;
                i_req = 1'b0;
            end
        end
        settle();
    endtask

    task automatic test_wait_cycles();
        int a0 = -1;
        int a1 = -1;
        int a3 = -1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; force_en = 1'b1; force_val = 32'h7766_5544;
        tick();
        d_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (z_d_ack && a0 < 0) a0 = c;
            if (d_ack && a1 < 0) a1 = c;
            if (t_d_ack && a3 < 0) a3 = c;
            tick();
        end
        chk_cnt++; if (a0 !== 2) $display("FAIL wait0_latency: got %0d expected 2", a0); else pass_cnt++;
        chk_cnt++; if (a1 !== 3) $display("FAIL wait1_latency: got %0d expected 3", a1); else pass_cnt++;
        chk_cnt++; if (a3 !== 5) $display("FAIL wait3_latency: got %0d expected 5", a3); else pass_cnt++;
        chk_cnt++; if ({z_d_rdata, t_d_rdata} !== {32'h7766_5544, 32'h7766_5544}) $display("FAIL wait_rdata: got %h expected 7766554477665544", {z_d_rdata, t_d_rdata}); else pass_cnt++;
        force_en = 1'b0;
        settle();
    endtask

    // Transaction-level model: a grant at an idle cycle t acks at t+W+2, next idle t+W+3.
    task automatic test_random();
        logic [31:0] model_mem [16];
        logic        inflight = 1'b0, fl_d = 1'b0, fl_we = 1'b0, pick_d, model_last = 1'b1;
        logic        active_i = 1'b0, active_d = 1'b0;
        logic [31:0] fl_addr = 32'h0, fl_wdata = 32'h0, exp_data = 32'h0;
        logic [31:0] exp_i_rdata = 32'h0, exp_d_rdata = 32'h0;
        logic [1:0]  exp_ack;
        int          exp_cycle = 0, next_free = 0;
        rst = 1'b1; mem_init = 1'b1; force_en = 1'b0; i_req = 1'b0; d_req = 1'b0;
        tick();
        rst = 1'b0; mem_init = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = init_val(i);
        for (int c = 0; c < 600; c++) begin
            exp_ack = (inflight && c == exp_cycle) ? (fl_d ? 2'b01 : 2'b10) : 2'b00;
            chk_cnt++; if ({i_ack, d_ack} !== exp_ack) $display("FAIL rnd_ack c%0d: got %b expected %b", c, {i_ack, d_ack}, exp_ack); else pass_cnt++;
            chk_cnt++; if ({busy, mem_en} !== {inflight, inflight && c < exp_cycle}) $display("FAIL rnd_busy_en c%0d: got %b expected %b", c, {busy, mem_en}, {inflight, inflight && c < exp_cycle}); else pass_cnt++;
            chk_cnt++; if ((mem_we & ~mem_en) !== 1'b0) $display("FAIL rnd_we_without_en c%0d: got 1 expected 0", c); else pass_cnt++;
            if (inflight && c < exp_cycle) begin
                chk_cnt++; if ({mem_addr, mem_we} !== {fl_addr, fl_we}) $display("FAIL rnd_bus c%0d: got %h/%b expected %h/%b", c, mem_addr, mem_we, fl_addr, fl_we); else pass_cnt++;
                if (fl_we) begin
                    chk_cnt++; if (mem_wdata !== fl_wdata) $display("FAIL rnd_wdata c%0d: got %h expected %h", c, mem_wdata, fl_wdata); else pass_cnt++;
                end
            end
            if (inflight && c == exp_cycle) begin
                if (!fl_d) exp_i_rdata = exp_data;
                else if (!fl_we) exp_d_rdata = exp_data;
                chk_cnt++; if ({i_rdata, d_rdata} !== {exp_i_rdata, exp_d_rdata}) $display("FAIL rnd_rdata c%0d: got %h/%h expected %h/%h", c, i_rdata, d_rdata, exp_i_rdata, exp_d_rdata); else pass_cnt++;
                inflight = 1'b0;
                if (fl_d) active_d = 1'b0; else active_i = 1'b0;
            end
            if (!active_i) begin
                if ($urandom_range(0, 2) == 0) begin
                    active_i = 1'b1; i_req = 1'b1; i_addr = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
                end else begin
                    i_req = 1'b0; i_addr = $urandom;
                end
            end
            if (!active_d) begin
                d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
                if ($urandom_range(0, 2) == 0) begin
                    active_d = 1'b1; d_req = 1'b1; d_addr = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
                end else begin
                    d_req = 1'b0; d_addr = $urandom;
                end
            end
            if (inflight && $urandom_range(0, 1) == 1) begin
                if (fl_d) begin
                    d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
                end else begin
                    i_addr = $urandom;
                end
            end
            if (!inflight && c == next_free) begin
                if (i_req || d_req) begin
`ifdef MIPS_MEM_ARB_RR_EN
                    pick_d = (i_req && d_req) ? ~model_last : d_req;
                    model_last = pick_d;
`else
                    pick_d = d_req;
`endif
                    fl_d = pick_d; fl_we = pick_d & d_we;
                    fl_addr = pick_d ? d_addr : i_addr; fl_wdata = d_wdata;
                    if (fl_we) model_mem[fl_addr[5:2]] = fl_wdata;
                    else exp_data = model_mem[fl_addr[5:2]];
                    inflight = 1'b1; exp_cycle = c + W + 2; next_free = c + W + 3;
                end else begin
                    next_free = c + 1;
                end
            end
            tick();
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_tie();
        test_reset_mid();
        test_wait_cycles();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
